reset_sequencer: RTL and testbench

//  Consumes the one-cycle active-low reset request (Req_L) from the master reset stage and

---
 rtl/reset_pkg.sv | 17 +
 rtl/seq_timer.sv | 29 ++
 rtl/reset_sequencer.sv | 126 ++++++++++++
 tb/tb_reset_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/reset_pkg.sv
// rtl/reset_pkg.sv - shared state encoding and default timing for the reset sequencer
package reset_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD    = 3'd1,
    REL_MEM = 3'd2,
    REL_REG = 3'd3,
    REL_PC  = 3'd4,
    DONE    = 3'd5
  } seq_state_t;

  localparam int DEF_HOLD_CYCLES = 4;
  localparam int DEF_GAP_CYCLES  = 2;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/seq_timer.sv
// rtl/seq_timer.sv - loadable down-counter with zero flag for hold/gap timing
module seq_timer #(
  parameter int               CNT_W       = 8,
  parameter logic [CNT_W-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Decrement is gated on non-zero so the counter can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RESET_VALUE;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - releases memory, register-file and PC resets in order after a request
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic             Req_L,
  output logic             Rst_Mem_L,
  output logic             Rst_Reg_L,
  output logic             Rst_PC_L,
  output logic             Ready,
  output logic [CNT_W-1:0] Seq_Count
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  seq_state_t       state, state_next;
  logic             mem_next, reg_next, pc_next, ready_next;
  logic             timer_load, timer_dec, timer_zero, count_inc;
  logic [CNT_W-1:0] timer_value;

  seq_timer #(
    .CNT_W       (CNT_W),
    .RESET_VALUE (HOLD_LOAD)
  ) u_timer (
    .clk        (CLK),
    .rst_n      (Reset_L),
    .load       (timer_load),
    .load_value (timer_value),
    .dec        (timer_dec),
    .zero       (timer_zero)
  );

  always_comb begin
    state_next  = state;
    mem_next    = Rst_Mem_L;
    reg_next    = Rst_Reg_L;
    pc_next     = Rst_PC_L;
    ready_next  = Ready;
    timer_load  = 1'b0;
    timer_dec   = 1'b0;
    timer_value = HOLD_LOAD;
    count_inc   = 1'b0;
    // A request wins in every state, including mid-hold and DONE.
    if (!Req_L) begin
      state_next = HOLD;
      mem_next   = 1'b0;
      reg_next   = 1'b0;
      pc_next    = 1'b0;
      ready_next = 1'b0;
      timer_load = 1'b1;
    end else begin
      case (state)
        IDLE: ;
        HOLD: begin
          if (timer_zero) begin
            state_next  = REL_MEM;
            mem_next    = 1'b1;
            timer_load  = 1'b1;
            timer_value = GAP_LOAD;
          end else begin
            timer_dec = 1'b1;
          end
        end
        REL_MEM: begin
          if (timer_zero) begin
            state_next  = REL_REG;
            reg_next    = 1'b1;
            timer_load  = 1'b1;
            timer_value = GAP_LOAD;
          end else begin
            timer_dec = 1'b1;
          end
        end
        REL_REG: begin
          if (timer_zero) begin
            state_next = REL_PC;
            pc_next    = 1'b1;
          end else begin
            timer_dec = 1'b1;
          end
        end
        REL_PC: begin
          state_next = DONE;
          ready_next = 1'b1;
          count_inc  = 1'b1;
        end
        DONE:    state_next = IDLE;
        default: begin
          state_next = HOLD;
          mem_next   = 1'b0;
          reg_next   = 1'b0;
          pc_next    = 1'b0;
          ready_next = 1'b0;
          timer_load = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state     <= HOLD;
      Rst_Mem_L <= 1'b0;
      Rst_Reg_L <= 1'b0;
      Rst_PC_L  <= 1'b0;
      Ready     <= 1'b0;
      Seq_Count <= '0;
    end else begin
      state     <= state_next;
      Rst_Mem_L <= mem_next;
      Rst_Reg_L <= reg_next;
      Rst_PC_L  <= pc_next;
      Ready     <= ready_next;
      if (count_inc && (Seq_Count != {CNT_W{1'b1}})) begin
        Seq_Count <= Seq_Count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
module tb_reset_sequencer;

  logic       CLK;
  logic       Reset_L, Req_L;
  logic       Rst_Mem_L, Rst_Reg_L, Rst_PC_L, Ready;
  logic [7:0] Seq_Count;

  logic       reset_f, req_f;
  logic       mem_f, reg_f, pc_f, ready_f;
  logic [1:0] count_f;

  int checks = 0;
  int errors = 0;

  reset_sequencer u_dut (
    .CLK       (CLK),
    .Reset_L   (Reset_L),
    .Req_L     (Req_L),
    .Rst_Mem_L (Rst_Mem_L),
    .Rst_Reg_L (Rst_Reg_L),
    .Rst_PC_L  (Rst_PC_L),
    .Ready     (Ready),
    .Seq_Count (Seq_Count)
  );

  reset_sequencer #(.HOLD_CYCLES(1), .GAP_CYCLES(1), .CNT_W(2)) u_fast (
    .CLK       (CLK),
    .Reset_L   (reset_f),
    .Req_L     (req_f),
    .Rst_Mem_L (mem_f),
    .Rst_Reg_L (reg_f),
    .Rst_PC_L  (pc_f),
    .Ready     (ready_f),
    .Seq_Count (count_f)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected {mem, reg, pc, ready} s edges after the request edge, from the latency rules.
  function automatic logic [3:0] exp_outs(input int s, input int h, input int g);
    return {s >= h, s >= h + g, s >= h + 2 * g, s >= h + 2 * g + 1};
  endfunction

  task automatic test_reset();
    logic [3:0] exp;
    Reset_L = 1'b0;
    Req_L   = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({Rst_Mem_L, Rst_Reg_L, Rst_PC_L, Ready, Seq_Count} !== 12'h000) begin
      errors++;
      $display("FAIL reset_values got %b/%0d exp 0000/0", {Rst_Mem_L, Rst_Reg_L, Rst_PC_L, Ready}, Seq_Count);
    end
    @(negedge CLK);
    Reset_L = 1'b1;
    for (int s = 1; s <= 12; s++) begin
      @(posedge CLK);
      #1;
      exp = exp_outs(s, 4, 2);
      checks++;
      if ({Rst_Mem_L, Rst_Reg_L, Rst_PC_L, Ready} !== exp || Seq_Count !== ((s >= 9) ? 8'd1 : 8'd0)) begin
        errors++;
        $display("FAIL power_on_seq s=%0d got %b/%0d exp %b/%0d", s,
                 {Rst_Mem_L, Rst_Reg_L, Rst_PC_L, Ready}, Seq_Count, exp, (s >= 9) ? 1 : 0);
      end
    end
  endtask

  task automatic test_request();
    logic [3:0] exp;
    for (int s = 0; s <= 12; s++) begin
      @(negedge CLK);
      Req_L = (s == 0) ? 1'b0 : 1'b1;
      @(posedge CLK);
      #1;
      exp = exp_outs(s, 4, 2);
      checks++;
      if ({Rst_Mem_L, Rst_Reg_L, Rst_PC_L, Ready} !== exp || Seq_Count !== ((s >= 9) ? 8'd2 : 8'd1)) begin
        errors++;
        $display("FAIL request_seq s=%0d got %b/%0d exp %b/%0d", s,
                 {Rst_Mem_L, Rst_Reg_L, Rst_PC_L, Ready}, Seq_Count, exp, (s >= 9) ? 2 : 1);
      end
    end
  endtask

  task automatic test_retrigger();
    logic [3:0] exp;
    for (int s = 0; s <= 17; s++) begin
      @(negedge CLK);
      Req_L = (s == 0 || s == 5) ? 1'b0 : 1'b1;
      @(posedge CLK);
      #1;
      exp = (s < 5) ? exp_outs(s, 4, 2) : exp_outs(s - 5, 4, 2);
      checks++;
      if ({Rst_Mem_L, Rst_Reg_L, Rst_PC_L, Ready} !== exp || Seq_Count !== ((s >= 14) ? 8'd3 : 8'd2)) begin
        errors++;
        $display("FAIL retrigger s=%0d got %b/%0d exp %b/%0d", s,
                 {Rst_Mem_L, Rst_Reg_L, Rst_PC_L, Ready}, Seq_Count, exp, (s >= 14) ? 3 : 2);
      end
    end
  endtask

  task automatic test_held_low();
    logic [3:0] exp;
    for (int s = 0; s <= 16; s++) begin
      @(negedge CLK);
      Req_L = (s <= 5) ? 1'b0 : 1'b1;
      @(posedge CLK);
      #1;
      exp = (s <= 5) ? 4'b0000 : exp_outs(s - 5, 4, 2);
      checks++;
      if ({Rst_Mem_L, Rst_Reg_L, Rst_PC_L, Ready} !== exp || Seq_Count !== ((s >= 14) ? 8'd4 : 8'd3)) begin
        errors++;
        $display("FAIL held_low s=%0d got %b/%0d exp %b/%0d", s,
                 {Rst_Mem_L, Rst_Reg_L, Rst_PC_L, Ready}, Seq_Count, exp, (s >= 14) ? 4 : 3);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp;
    for (int s = 0; s <= 7; s++) begin
      @(negedge CLK);
      Req_L = (s == 0) ? 1'b0 : 1'b1;
      @(posedge CLK);
    end
    #1;
    checks++;
    if ({Rst_Mem_L, Rst_Reg_L, Rst_PC_L, Ready} !== 4'b1100) begin
      errors++;
      $display("FAIL mid_rel_reg got %b exp 1100", {Rst_Mem_L, Rst_Reg_L, Rst_PC_L, Ready});
    end
    Reset_L = 1'b0;
    #1;
    checks++;
    if ({Rst_Mem_L, Rst_Reg_L, Rst_PC_L, Ready, Seq_Count} !== 12'h000) begin
      errors++;
      $display("FAIL async_reset got %b/%0d exp 0000/0", {Rst_Mem_L, Rst_Reg_L, Rst_PC_L, Ready}, Seq_Count);
    end
    @(negedge CLK);
    Reset_L = 1'b1;
    for (int s = 1; s <= 12; s++) begin
      @(posedge CLK);
      #1;
      exp = exp_outs(s, 4, 2);
      checks++;
      if ({Rst_Mem_L, Rst_Reg_L, Rst_PC_L, Ready} !== exp || Seq_Count !== ((s >= 9) ? 8'd1 : 8'd0)) begin
        errors++;
        $display("FAIL rerun_seq s=%0d got %b/%0d exp %b/%0d", s,
                 {Rst_Mem_L, Rst_Reg_L, Rst_PC_L, Ready}, Seq_Count, exp, (s >= 9) ? 1 : 0);
      end
    end
  endtask

  task automatic test_saturate();
    logic [3:0] exp;
    logic [1:0] cexp;
    reset_f = 1'b0;
    req_f   = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    reset_f = 1'b1;
    for (int s = 1; s <= 6; s++) begin
      @(posedge CLK);
      #1;
      exp = exp_outs(s, 1, 1);
      checks++;
      if ({mem_f, reg_f, pc_f, ready_f} !== exp || count_f !== ((s >= 4) ? 2'd1 : 2'd0)) begin
        errors++;
        $display("FAIL fast_power_on s=%0d got %b/%0d exp %b/%0d", s,
                 {mem_f, reg_f, pc_f, ready_f}, count_f, exp, (s >= 4) ? 1 : 0);
      end
    end
    for (int r = 1; r <= 4; r++) begin
      for (int s = 0; s <= 6; s++) begin
        @(negedge CLK);
        req_f = (s == 0) ? 1'b0 : 1'b1;
        @(posedge CLK);
        #1;
        exp  = exp_outs(s, 1, 1);
        cexp = 2'(((r + ((s >= 4) ? 1 : 0)) > 3) ? 3 : (r + ((s >= 4) ? 1 : 0)));
        checks++;
        if ({mem_f, reg_f, pc_f, ready_f} !== exp || count_f !== cexp) begin
          errors++;
          $display("FAIL saturate r=%0d s=%0d got %b/%0d exp %b/%0d", r, s,
                   {mem_f, reg_f, pc_f, ready_f}, count_f, exp, cexp);
        end
      end
    end
  endtask

  initial begin
    Reset_L = 1'b0;
    Req_L   = 1'b1;
    reset_f = 1'b0;
    req_f   = 1'b1;
    test_reset();
    test_request();
    test_retrigger();
    test_held_low();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
